// File: rtl/hit_gen.sv
// Pulse generator for a TDC: arms the enable, launches a hit of programmed width, then captures the result, flags a timeout, or flags a done that came too early.
// Latency: oEnable rises 1 cycle after iStart is sampled and oHit 1+ARM_CYC cycles after it. No backpressure: iStart is taken only in IDLE.
module hit_gen #(
    parameter int DIG_OUT    = 32,
    parameter int WIDTH_BITS = 8,
    parameter int ARM_CYC    = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic [WIDTH_BITS-1:0] iWidth,
    output logic                  oEnable,
    output logic                  oHit,
    input  logic                  iDone,
    input  logic [DIG_OUT-1:0]    iTDC,
    output logic [DIG_OUT-1:0]    oResult,
    output logic                  oValid,
    output logic [1:0]            oStatus,
    output logic                  oBusy,
    output logic [15:0]           oCount
);

    localparam int MAX_W = (1 << WIDTH_BITS);
    localparam int MAX_A = (TIMEOUT > ARM_CYC) ? TIMEOUT : ARM_CYC;
    localparam int MAX_V = (MAX_A > MAX_W) ? MAX_A : MAX_W;
    localparam int CNT_W = $clog2(MAX_V + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_EARLY   = 2'b10;

    // One-hot so that each output is a flop bit rather than a decode.
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ARM  = 5'b00010,
        S_HIGH = 5'b00100,
        S_WAIT = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [WIDTH_BITS-1:0] r_w;
    logic [DIG_OUT-1:0]    r_result;
    logic [1:0]            r_status;
    logic [15:0]           r_count;

    logic                  w_arm_last;
    logic                  w_high_last;
    logic                  w_timeout;
    logic [WIDTH_BITS-1:0] w_w_in;

    assign w_arm_last  = (r_cnt == CNT_W'(ARM_CYC - 1));
    assign w_high_last = ((r_cnt + CNT_ONE) == CNT_W'(r_w));
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_w_in      = (iWidth == '0) ? WIDTH_BITS'(1) : iWidth;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (iStart) w_next = S_ARM;
            S_ARM:  if (w_arm_last) w_next = S_HIGH;
            S_HIGH: begin
                if (iDone)            w_next = S_DONE;
                else if (w_high_last) w_next = S_WAIT;
            end
            S_WAIT: if (iDone || w_timeout) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_w      <= '0;
            r_result <= '0;
            r_status <= ST_OK;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            // The counter restarts at 0 on every state change and idles at 0.
            if ((w_next != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
            else                                            r_cnt <= r_cnt + CNT_ONE;

            if ((r_state == S_IDLE) && iStart) r_w <= w_w_in;

            if ((r_state == S_HIGH) && iDone) begin
                r_result <= iTDC;
                r_status <= ST_EARLY;
                r_count  <= r_count + 16'd1;
            end else if ((r_state == S_WAIT) && iDone) begin
                r_result <= iTDC;
                r_status <= ST_OK;
                r_count  <= r_count + 16'd1;
            end else if ((r_state == S_WAIT) && w_timeout) begin
                r_result <= '0;
                r_status <= ST_TIMEOUT;
                r_count  <= r_count + 16'd1;
            end
        end
    end

    assign oHit    = r_state[2];
    assign oEnable = r_state[1] | r_state[2] | r_state[3];
    assign oValid  = r_state[4];
    assign oBusy   = ~r_state[0];
    assign oResult = r_result;
    assign oStatus = r_status;
    assign oCount  = r_count;

endmodule

// File: doc/hit_gen.md
HIT_GEN -- requirements
Module: hit_gen

Interface
REQ-001 Parameter DIG_OUT, default 32: width of the TDC result word captured from the TDC.
REQ-002 Parameter WIDTH_BITS, default 8: width of the programmed pulse-width field.
REQ-003 Parameter ARM_CYC, default 4: cycles oEnable is held high before the hit is launched (ARM_CYC >= 3).
REQ-004 Parameter TIMEOUT, default 1024: maximum WAIT cycles before the measurement is abandoned.
REQ-005 Port iClk  in  1  single clock; all logic is on its rising edge.
REQ-006 Port iRst  in  1  asynchronous, active-high reset.
REQ-007 Port iStart  in  1  request one measurement; sampled only in IDLE.
REQ-008 Port iWidth  in  WIDTH_BITS  hit high-time in iClk cycles; latched when iStart is accepted.
REQ-009 Port oEnable  out  1  drives the TDC enable.
REQ-010 Port oHit  out  1  drives the TDC iHit; registered output.
REQ-011 Port iDone  in  1  TDC done strobe.
REQ-012 Port iTDC  in  DIG_OUT  TDC result word; valid while iDone is high.
REQ-013 Port oResult  out  DIG_OUT  captured result; held until the next capture.
REQ-014 Port oValid  out  1  one-cycle strobe; oResult and oStatus are valid.
REQ-015 Port oStatus  out  2  00 ok, 01 timeout, 10 early done (iDone during HIGH), 11 unused.
REQ-016 Port oBusy  out  1  high in every state except IDLE.
REQ-017 Port oCount  out  16  number of oValid strobes since reset; wraps 0xFFFF -> 0x0000.

Function
REQ-018 The FSM SHALL have the states IDLE, ARM, HIGH, WAIT and DONE, using a one-hot or binary encoding.
REQ-019 IDLE: when iStart=1, latch W = max(iWidth,1) and go to ARM on the next edge; otherwise stay in IDLE.
REQ-020 ARM: oEnable=1 and oHit=0 for exactly ARM_CYC cycles, then go to HIGH.
REQ-021 HIGH: oHit=1 for exactly W consecutive cycles, then go to WAIT; oEnable stays 1.
REQ-022 HIGH with iDone=1: capture iTDC, set status 10, drop oHit on the next edge and go to DONE.
REQ-023 WAIT: oHit=0 and oEnable=1; a cycle counter starts at 0 on entry.
REQ-024 WAIT with iDone=1: capture iTDC into oResult, set status 00 and go to DONE.
REQ-025 WAIT with the counter at TIMEOUT-1 and iDone=0: set oResult to 0, set status 01 and go to DONE.
REQ-026 iDone=1 and timeout in the same cycle: the done capture (status 00) wins.
REQ-027 DONE: lasts one cycle; oValid=1, oEnable=0, oHit=0, oCount increments; next state is IDLE.
REQ-028 iDone in ARM, DONE or IDLE SHALL be ignored.
REQ-029 iStart outside IDLE SHALL be ignored and not queued.
REQ-030 iWidth changes after acceptance SHALL NOT affect the pulse in flight.
REQ-031 Latency from the iStart-sampling edge: oEnable rises after 1 cycle and oHit rises after 1+ARM_CYC cycles.
REQ-032 Back-to-back operation: iStart held high re-arms from IDLE, giving at least one IDLE cycle between measurements.

Reset
REQ-033 iRst=1 SHALL immediately force the following, independent of iClk: state IDLE, oHit=0, oEnable=0, oValid=0, oBusy=0, oStatus=00, oResult=0, oCount=0, W=0, WAIT counter=0.
REQ-034 Reset mid-operation SHALL abandon the measurement with no oValid strobe.
REQ-035 After iRst falls, iStart is accepted on the first rising edge.

Verification
REQ-036 iWidth=5, TDC model asserts iDone 3 cycles after oHit falls with iTDC=0x0000ABCD -> oHit high exactly 5 cycles; oResult=0x0000ABCD; oStatus=00; one oValid; oCount=1.
REQ-037 iWidth=0 -> oHit high exactly 1 cycle.
REQ-038 iDone never asserted, TIMEOUT=16 -> oValid exactly 16 cycles after WAIT entry; oStatus=01; oResult=0.
REQ-039 iDone pulsed in the 2nd HIGH cycle of a W=10 pulse -> oHit drops after 2 cycles; oStatus=10; iTDC captured.
REQ-040 iRst asserted during HIGH -> oHit=0 before the next edge; no oValid; oCount=0; a new iStart after release runs normally.
REQ-041 iStart held high for 3 measurements, plus a pulse during WAIT -> exactly 3 oValid strobes (the WAIT pulse is ignored); oCount=3; oBusy low for at least 1 cycle between measurements; 65536 runs wrap oCount to 0.
